// File: rtl/present_enc_iter.sv
// Iterative PRESENT-64 encryptor, one round per clock, on-the-fly key schedule.
// Supports 80- and 128-bit keys; valid/ready handshake on input and output.
module present_enc_iter #(
  parameter int unsigned KEY_SIZE   = 80,
  parameter int unsigned NUM_ROUNDS = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_SIZE-1:0] key,
  input  logic [63:0]         plaintext,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         ciphertext
);

  if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
    $error("present_enc_iter: KEY_SIZE must be 80 or 128");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
    $error("present_enc_iter: NUM_ROUNDS must be in 1..31");
  end

  // S-box table, entry x at bits [4x+3:4x].
  localparam logic [63:0] SboxLut = 64'h2174_8FE3_DA09_B65C;
  localparam logic [4:0]  LastRc  = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e                fsm_q;
  logic [63:0]         state_q;
  logic [KEY_SIZE-1:0] kreg_q;
  logic [4:0]          rc_q;

  logic [63:0]         round_t;
  logic [KEY_SIZE-1:0] key_rot;
  logic [KEY_SIZE-1:0] key_upd;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SboxLut[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r[63] = x[63];
    for (int i = 0; i < 63; i++) begin
      r[(16 * i) % 63] = x[i];
    end
    return r;
  endfunction

  assign in_ready   = (fsm_q == StIdle) && rst_n;
  assign out_valid  = (fsm_q == StDone);
  assign ciphertext = state_q;

  // Rotate left by 61.
  assign key_rot = {kreg_q[KEY_SIZE-62:0], kreg_q[KEY_SIZE-1:KEY_SIZE-61]};

  if (KEY_SIZE == 128) begin : g_upd128
    // 128-bit schedule: two S-boxes on the top byte, counter folded into [66:62].
    always_comb begin
      key_upd          = key_rot;
      key_upd[127:124] = sbox4(key_rot[127:124]);
      key_upd[123:120] = sbox4(key_rot[123:120]);
      key_upd[66:62]   = key_rot[66:62] ^ rc_q;
    end
  end else begin : g_upd80
    // 80-bit schedule: one S-box on the top nibble, counter folded into [19:15].
    always_comb begin
      key_upd        = key_rot;
      key_upd[79:76] = sbox4(key_rot[79:76]);
      key_upd[19:15] = key_rot[19:15] ^ rc_q;
    end
  end

  // One full round: addRoundKey, sBox, pLayer.
  always_comb begin
    round_t = p_layer(s_layer(state_q ^ kreg_q[KEY_SIZE-1 -: 64]));
  end

  // Control FSM plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      kreg_q  <= '0;
      rc_q    <= '0;
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= plaintext;
            kreg_q  <= key;
            rc_q    <= 5'd1;
            fsm_q   <= StRun;
          end
        end
        StRun: begin
          kreg_q <= key_upd;
          rc_q   <= rc_q + 5'd1;
          if (rc_q == LastRc) begin
            // Final whitening key folded into the last round.
            state_q <= round_t ^ key_upd[KEY_SIZE-1 -: 64];
            fsm_q   <= StDone;
          end else begin
            state_q <= round_t;
          end
        end
        StDone: begin
          if (out_ready) fsm_q <= StIdle;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_present_enc_iter.sv
// Directed bench for present_enc_iter: 80-bit default, 128-bit, and 1-round variants.
module tb_present_enc_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_bus;
  logic [63:0]  pt;
  logic [2:0]   iv;
  logic [2:0]   orr;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [63:0]  ct [3];

  int checks = 0;
  int errors = 0;
  int sel;
  logic ov_sel, ir_sel;
  logic [63:0] ct_sel;

  always #5 clk = ~clk;

  present_enc_iter #(.KEY_SIZE(80), .NUM_ROUNDS(31)) dut80 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .key(key_bus[79:0]),
    .plaintext(pt), .out_valid(ov[0]), .out_ready(orr[0]), .ciphertext(ct[0])
  );
  present_enc_iter #(.KEY_SIZE(128), .NUM_ROUNDS(31)) dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .key(key_bus),
    .plaintext(pt), .out_valid(ov[1]), .out_ready(orr[1]), .ciphertext(ct[1])
  );
  present_enc_iter #(.KEY_SIZE(80), .NUM_ROUNDS(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .key(key_bus[79:0]),
    .plaintext(pt), .out_valid(ov[2]), .out_ready(orr[2]), .ciphertext(ct[2])
  );

  always_comb begin
    ov_sel = ov[sel];
    ir_sel = ir[sel];
    ct_sel = ct[sel];
  end

  // Reference model pieces for the reduced-round case.
  function automatic logic [63:0] m_sbox_layer(input logic [63:0] x);
    logic [3:0] tbl [16];
    logic [63:0] r;
    tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    for (int n = 0; n < 16; n++) r[4*n +: 4] = tbl[x[4*n +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] m_player(input logic [63:0] x);
    logic [63:0] r;
    r[63] = x[63];
    for (int i = 0; i < 63; i++) r[(16 * i) % 63] = x[i];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a block at the current (post-edge) time and let the next edge accept it.
  task automatic accept(input int s, input logic [127:0] k, input logic [63:0] p,
                        input string tag);
    sel     = s;
    key_bus = k;
    pt      = p;
    iv[s]   = 1'b1;
    #0;
    check_eq({tag, "_in_ready"}, 64'(ir_sel), 64'd1);
    @(posedge clk); #1;
    iv[s]   = 1'b0;
    key_bus = '1;
    pt      = '1;
  endtask

  task automatic wait_valid(input int s, input int lat, input string tag, output bit ok);
    int n;
    sel = s;
    n   = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (ov_sel) begin
        n = c;
        break;
      end
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(lat));
    ok = (n > 0);
  endtask

  task automatic drain(input int s, input string tag);
    sel    = s;
    orr[s] = 1'b1;
    @(posedge clk); #1;
    orr[s] = 1'b0;
    check_eq({tag, "_ov_after"}, 64'(ov_sel), 64'd0);
    check_eq({tag, "_ir_after"}, 64'(ir_sel), 64'd1);
  endtask

  task automatic run_block(input int s, input logic [127:0] k, input logic [63:0] p,
                           input logic [63:0] exp, input int lat, input string tag);
    bit ok;
    accept(s, k, p, tag);
    wait_valid(s, lat, tag, ok);
    if (ok) begin
      check_eq({tag, "_ct"}, ct_sel, exp);
      drain(s, tag);
    end
  endtask

  localparam logic [127:0] Ones80 = {48'h0, {80{1'b1}}};

  initial begin
    bit ok;
    logic [63:0] exp_r1;
    iv = '0; orr = '0; key_bus = '0; pt = '0; sel = 0;
    rst_n = 1'b0;
    #1;
    check_eq("ready_in_reset", 64'(ir[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #0;
    for (int s = 0; s < 3; s++) begin
      check_eq($sformatf("rst_ov%0d", s), 64'(ov[s]), 64'd0);
      check_eq($sformatf("rst_ct%0d", s), ct[s], 64'd0);
      check_eq($sformatf("rst_ir%0d", s), 64'(ir[s]), 64'd1);
    end

    run_block(0, 128'h0, 64'h0, 64'h5579C1387B228445, 31, "v80_zero");
    run_block(0, 128'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2 ^ 64'h0 ^
              (64'hA112FFC72F68417B ^ 64'h3333DCD3213210D2), 31, "v80_pt1");
    run_block(0, Ones80, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2, 31, "v80_k1pt1");

    // Backpressure: result held 10 cycles while a new block waits on in_valid.
    accept(0, 128'h0, 64'h0, "bp_a");
    wait_valid(0, 31, "bp_a", ok);
    if (ok) begin
      key_bus = Ones80;
      pt      = 64'h0;
      iv[0]   = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check_eq("bp_ct_stable", ct_sel, 64'h5579C1387B228445);
        check_eq("bp_ov_held", 64'(ov_sel), 64'd1);
        check_eq("bp_ir_low", 64'(ir_sel), 64'd0);
      end
      orr[0] = 1'b1;
      @(posedge clk); #1;
      orr[0] = 1'b0;
      check_eq("bp_ov_drop", 64'(ov_sel), 64'd0);
      check_eq("bp_ir_back", 64'(ir_sel), 64'd1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      check_eq("bp_b_taken", 64'(ir_sel), 64'd0);
      wait_valid(0, 31, "bp_b", ok);
      if (ok) begin
        check_eq("bp_b_ct", ct_sel, 64'hE72C46C0F5945049);
        drain(0, "bp_b");
      end
    end else begin
      iv[0] = 1'b0;
    end

    // Reset at round 12 aborts the block.
    accept(0, 128'h0, 64'h0, "mid_rst");
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #0;
    check_eq("mid_rst_ir_low", 64'(ir_sel), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #0;
    check_eq("mid_rst_ov", 64'(ov_sel), 64'd0);
    check_eq("mid_rst_ct", ct_sel, 64'd0);
    check_eq("mid_rst_ir", 64'(ir_sel), 64'd1);
    run_block(0, 128'h0, 64'h0, 64'h5579C1387B228445, 31, "after_rst");

    run_block(1, 128'h0, 64'h0, 64'h96DB702A2E6900AF, 31, "v128_zero");

    // One round: round key 0, whitening key = upd(0,1)[79:16] = C000_0000_0000_0000.
    exp_r1 = m_player(m_sbox_layer(64'h0)) ^ 64'hC000_0000_0000_0000;
    run_block(2, 128'h0, 64'h0, exp_r1, 1, "r1_zero");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/present_enc_iter.md
# present_enc_iter

Iterative, parametrised PRESENT block-cipher encryptor: one round per clock, with a valid/ready handshake on both input and output. It supports 80-bit and 128-bit keys and a configurable round count. Key scheduling is done on the fly, so there is no stored round-key array. It sits between the crypto command front-end, which supplies key and plaintext, and the result collector, which drains ciphertext under backpressure.

## Interface
- `KEY_SIZE`, default 80: key width. Legal values are 80 and 128; any other value is an elaboration error.
- `NUM_ROUNDS`, default 31: number of full rounds (addRoundKey, sBox, pLayer). Legal range is 1..31; outside that is an elaboration error.
- Block size is fixed at 64.
- `clk` input, 1 bit: single clock; every register updates on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: `key` and `plaintext` are valid.
- `in_ready` output, 1 bit: core can accept a block.
- `key` input, `KEY_SIZE` bits: cipher key; MSB is key bit `KEY_SIZE-1`.
- `plaintext` input, 64 bits: input block.
- `out_valid` output, 1 bit: `ciphertext` is valid.
- `out_ready` input, 1 bit: downstream accepts the ciphertext.
- `ciphertext` output, 64 bits: result, driven directly from the state register.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- `in_ready` = (FSM == IDLE) && `rst_n`.
- `out_valid` = (FSM == DONE).
- Accept occurs on an edge where IDLE && `in_valid`:
  - `state` <= `plaintext`
  - `kreg` <= `key`
  - `rc` <= 1
  - FSM -> RUN
- Each RUN edge:
  - T = pLayer(sBox(`state` ^ `kreg[KEY_SIZE-1 -: 64]`)).
  - `kreg` <= upd(`kreg`, `rc`), then `rc` <= `rc` + 1.
  - When `rc` == `NUM_ROUNDS`:
    - `state` <= T ^ upd(`kreg`,`rc`)[KEY_SIZE-1 -: 64], i.e. the final whitening key is applied on the same edge.
    - FSM -> DONE.
  - Otherwise `state` <= T.
- DONE edge with `out_ready` = 1: FSM -> IDLE. `state` and `ciphertext` are not cleared.
- sBox: each nibble x maps through C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for x = 0..F.
- pLayer: bit i moves to position (16·i) mod 63 for i = 0..62; bit 63 stays at 63.
- upd, 80-bit key:
  - Rotate left by 61.
  - Bits [79:76] <= sBox([79:76]).
  - Bits [19:15] ^= `rc[4:0]`.
- upd, 128-bit key:
  - Rotate left by 61.
  - Bits [127:124] and [123:120] each pass through the sBox.
  - Bits [66:62] ^= `rc[4:0]`.
- `rc` is 5 bits wide and never wraps, because `NUM_ROUNDS` ≤ 31.
- `in_valid` is ignored outside IDLE; `key` and `plaintext` may change freely after accept.
- `out_ready` is ignored outside DONE.

## Timing
- Reset: when `rst_n` = 0 on an edge, FSM -> IDLE and `state`, `kreg` and `rc` -> 0. Outputs after that edge are `out_valid` = 0, `ciphertext` = 0 and `in_ready` = 1.
- While `rst_n` is low, `in_ready` = 0 combinationally.
- Reset mid-RUN or mid-DONE aborts the block, and the result is never presented.
- Latency: accept on edge E0, `out_valid` high after edge E`NUM_ROUNDS` (31 cycles by default).
- `ciphertext` is stable and `out_valid` stays high until the handshake edge.
- Throughput: one block per `NUM_ROUNDS`+2 cycles with `out_ready` tied high. `in_ready` returns high in the cycle after the output handshake; the same-cycle turnaround is not supported.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Test plan
- 80-bit, default rounds, zero vectors: `key` = 0, `plaintext` = 0 -> `ciphertext` 5579C1387B228445, with `out_valid` rising exactly 31 cycles after accept.
- 80-bit, remaining standard vectors:
  - `key` = all ones (80 bits), `plaintext` = 0 -> E72C46C0F5945049.
  - `key` = 0, `plaintext` = FFFFFFFFFFFFFFFF -> A112FFC72F68417B.
  - `key` = all ones, `plaintext` = FFFFFFFFFFFFFFFF -> 3333DCD3213210D2.
- 128-bit: `KEY_SIZE` = 128, `key` = 0, `plaintext` = 0 -> 96DB702A2E6900AF.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid` rises.
  - `ciphertext` is stable and `in_ready` = 0 throughout, even with `in_valid` held high.
  - The second block is accepted only in the cycle after the output handshake.
- Reset mid-operation: assert `rst_n` = 0 for one edge at round 12.
  - Next cycle shows `out_valid` = 0, `ciphertext` = 0 and `in_ready` = 1.
  - A fresh zero-vector run then produces 5579C1387B228445.
- Reduced rounds: `NUM_ROUNDS` = 1, `KEY_SIZE` = 80, `key` = 0, `plaintext` = 0.
  - `out_valid` rises 1 cycle after accept.
  - `ciphertext` = pLayer(sBox(0)) ^ upd(0,1)[79:16], checked against the bench reference model.
